uart_reg_responder: RTL
=======================

Name: uart_reg_responder

Overview:
- Byte-level command responder that sits on top of the existing UART byte interface (received/rx_byte/recv_error in, transmit/tx_byte/is_transmitting out).
- Decodes host read/write frames, performs single-cycle register accesses on an external register bank, and returns ACK/NAK/data frames through the UART transmitter.
- Provides host access to the PMCO2 board's configuration and status registers.

Parameters:
- TIMEOUT_CYCLES, 70000, clk cycles allowed between bytes of one frame (10 ms at 7 MHz); 17-bit counter.
- CMD_READ, 8'h52, read command byte ('R').
- CMD_WRITE, 8'h57, write command byte ('W').
- ACK, 8'h06, positive response byte.
- NAK, 8'h15, checksum-failure response byte.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle strobe, from UART received
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_err  in  1  one-cycle strobe, from UART recv_error
- tx_start  out  1  one-cycle strobe, to UART transmit
- tx_data  out  8  byte to send, held stable while tx_start=1
- tx_busy  in  1  from UART is_transmitting
- reg_addr  out  8  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- frame_err  out  1  one-cycle pulse on timeout or rx_err abort
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, highest priority, including mid-frame or mid-send):
  - State returns to IDLE.
  - tx_start=0, tx_data=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_err=0, busy=0.
  - Checksum accumulator=0, timeout counter=0.
- Frame formats (host to block):
  - Read: CMD_READ, addr, chk.
  - Write: CMD_WRITE, addr, data, chk.
  - chk = XOR of all preceding bytes in the frame.
- States: IDLE, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_CAPTURE, SEND_WAIT, SEND_BUSY.
- IDLE:
  - rx_valid with CMD_READ or CMD_WRITE: latch command, acc=byte, go to GET_ADDR.
  - Any other byte: silently discarded (resync), no response.
- GET_ADDR: on rx_valid, latch reg_addr and XOR into acc. Next state is GET_DATA for a write, GET_CHK for a read.
- GET_DATA: on rx_valid, latch reg_wdata, XOR into acc, go to GET_CHK.
- GET_CHK: on rx_valid, compare byte with acc, go to EXEC.
- EXEC (one cycle):
  - Checksum mismatch: queue response {NAK}; no reg_we or reg_re is issued.
  - Write with good checksum: reg_we=1 for this cycle only; queue {ACK}.
  - Read with good checksum: reg_re=1 for this cycle only; go to RD_CAPTURE.
- RD_CAPTURE: capture reg_rdata (the cycle after reg_re); queue {ACK, d, ACK^d}.
- Send loop (response length 1 or 3 bytes):
  - SEND_WAIT: when tx_busy=0, drive tx_data=byte[i] and tx_start=1 for exactly one cycle, go to SEND_BUSY.
  - SEND_BUSY: wait for tx_busy=1.
    - If more bytes remain: i++, back to SEND_WAIT.
    - After the last byte: go to IDLE. The last byte may still be on the line; the next response waits in SEND_WAIT.
- Timeout:
  - Counter clears on every rx_valid and counts only in GET_ADDR, GET_DATA and GET_CHK.
  - On reaching TIMEOUT_CYCLES: frame_err=1 for one cycle, go to IDLE, no response.
- rx_err in GET_ADDR, GET_DATA or GET_CHK: frame_err pulse, go to IDLE, no response.
- rx_err in IDLE: ignored.
- rx_valid during EXEC, RD_CAPTURE, SEND_WAIT or SEND_BUSY: byte dropped, no error. The host must wait for the full response before sending the next frame.
- rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
- Register access latency:
  - Write: reg_we is asserted 1 cycle after the checksum byte's rx_valid.
  - Read: reg_re is asserted 1 cycle after the checksum byte's rx_valid, and the first tx_start occurs no earlier than 2 cycles after it.
- reg_addr and reg_wdata hold their values until the next frame overwrites them.

Test Plan:
- Read: rx 52,10,42 with reg_rdata=A5 -> one reg_re with reg_addr=10; tx bytes 06,A5,A3 in order, one tx_start per byte, each issued only while tx_busy=0.
- Write: rx 57,20,3C,4B -> one reg_we with reg_addr=20, reg_wdata=3C; tx 06; no reg_re.
- Bad checksum: rx 57,20,3C,00 -> no reg_we; tx 15 only.
- Timeout: rx 52, then idle for TIMEOUT_CYCLES -> frame_err pulse, busy=0, no tx. A following rx 52,10,42 is answered normally.
- rx_err after byte 57,20 -> frame_err pulse, no reg access, no tx. Junk byte 41 in IDLE -> ignored.
- Reset asserted during SEND_BUSY of byte 2 of a read response -> all outputs at reset values, no further tx_start; a following valid write completes with ACK.

Source files
------------

// File: rtl/uart_reg_responder.sv
// uart_reg_responder
//   Host command responder sitting on the UART byte interface. Decodes
//   read frames (R, addr, chk) and write frames (W, addr, data, chk), where
//   chk is the XOR of the preceding frame bytes, performs a single-cycle
//   access on an external register bank and answers through the UART
//   transmitter with {NAK}, {ACK} or {ACK, data, ACK^data}.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rx_valid, rx_data     received byte strobe and byte
//   rx_err                receive error strobe (aborts a frame in progress)
//   tx_start, tx_data     transmit strobe and byte to the UART
//   tx_busy               UART transmitter busy
//   reg_addr, reg_wdata   register address / write data (held between frames)
//   reg_we, reg_re        one-cycle register write / read strobes
//   reg_rdata             register read data, valid 1 cycle after reg_re
//   frame_err             one-cycle pulse on timeout or rx_err abort
//   busy                  high whenever a frame or response is in progress
module uart_reg_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 70000,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  ACK            = 8'h06,
  parameter logic [7:0]  NAK            = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_CAPTURE, SEND_WAIT, SEND_BUSY
  } state_t;

  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic            is_write;
  logic            chk_ok;
  logic [7:0]      acc;
  logic [16:0]     timer;
  logic [2:0][7:0] resp;
  logic [1:0]      idx;
  logic [1:0]      last_idx;

  logic in_frame;
  logic abort;
  logic chk_match;

  assign in_frame  = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CHK);
  // A received byte beats a simultaneous timeout; rx_err always aborts.
  assign abort     = in_frame && (rx_err || (!rx_valid && timer == TIMEOUT_LAST));
  assign chk_match = (rx_data == acc);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      chk_ok    <= 1'b0;
      acc       <= '0;
      timer     <= '0;
      resp      <= '0;
      idx       <= '0;
      last_idx  <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid) begin
        timer <= '0;
      end else if (in_frame) begin
        timer <= timer + 17'd1;
      end

      if (abort) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
              is_write <= (rx_data == CMD_WRITE);
              acc      <= rx_data;
              state    <= GET_ADDR;
            end
          end
          GET_ADDR: begin
            if (rx_valid) begin
              reg_addr <= rx_data;
              acc      <= acc ^ rx_data;
              state    <= is_write ? GET_DATA : GET_CHK;
            end
          end
          GET_DATA: begin
            if (rx_valid) begin
              reg_wdata <= rx_data;
              acc       <= acc ^ rx_data;
              state     <= GET_CHK;
            end
          end
          GET_CHK: begin
            // Strobes are raised here so they are high during the EXEC cycle,
            // one cycle after the checksum byte arrives.
            if (rx_valid) begin
              chk_ok <= chk_match;
              reg_we <= is_write && chk_match;
              reg_re <= !is_write && chk_match;
              state  <= EXEC;
            end
          end
          EXEC: begin
            idx <= '0;
            if (!chk_ok) begin
              resp[0]  <= NAK;
              last_idx <= 2'd0;
              state    <= SEND_WAIT;
            end else if (is_write) begin
              resp[0]  <= ACK;
              last_idx <= 2'd0;
              state    <= SEND_WAIT;
            end else begin
              state    <= RD_CAPTURE;
            end
          end
          RD_CAPTURE: begin
            resp     <= {ACK ^ reg_rdata, reg_rdata, ACK};
            last_idx <= 2'd2;
            state    <= SEND_WAIT;
          end
          SEND_WAIT: begin
            if (!tx_busy) begin
              tx_data  <= resp[idx];
              tx_start <= 1'b1;
              state    <= SEND_BUSY;
            end
          end
          SEND_BUSY: begin
            if (tx_busy) begin
              if (idx == last_idx) begin
                state <= IDLE;
              end else begin
                idx   <= idx + 2'd1;
                state <= SEND_WAIT;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
